mem_wb: RTL and testbench

MEM_WB -- requirements
Module: mem_wb

---
 rtl/mem_wb_pkg.sv | 38 +++
 rtl/mem_wb_if.sv | 35 +++
 rtl/mem_wb_load_align.sv | 38 +++
 rtl/mem_wb.sv | 136 +++++++++++++
 tb/tb_mem_wb.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pkg.sv
// Shared load/store definitions: byte-strobe encodings, access modes, FSM states.
package mem_wb_pkg;

    // Load byte strobes as presented by the LSU; zero means "not a load".
    localparam logic [3:0] StrbNone   = 4'b0000;
    localparam logic [3:0] StrbWord   = 4'b1111;
    localparam logic [3:0] StrbHalfLo = 4'b0011;
    localparam logic [3:0] StrbHalfHi = 4'b1100;
    localparam logic [3:0] StrbByte0  = 4'b0001;
    localparam logic [3:0] StrbByte1  = 4'b0010;
    localparam logic [3:0] StrbByte2  = 4'b0100;
    localparam logic [3:0] StrbByte3  = 4'b1000;

    typedef enum logic [1:0] {
        ModeNone,
        ModeByte,
        ModeHalf,
        ModeWord
    } ls_mode_e;

    typedef enum logic {
        StIdle,
        StWait
    } wb_state_e;

    // Classify a strobe; anything that is not a legal aligned pattern is ModeNone.
    function automatic ls_mode_e strb_mode(input logic [3:0] strb);
        ls_mode_e mode;
        case (strb)
            StrbWord:                                  mode = ModeWord;
            StrbHalfLo, StrbHalfHi:                    mode = ModeHalf;
            StrbByte0, StrbByte1, StrbByte2, StrbByte3: mode = ModeByte;
            default:                                   mode = ModeNone;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/mem_wb_if.sv
// LSU / memory-response / register-file-write bundle for the write-back stage.
interface mem_wb_if;
    import mem_wb_pkg::*;

    logic [31:0] lsu_out;
    logic        lsu_out_vld;
    logic [4:0]  lsu_rd;
    logic        lsu_rd_wen;
    logic [3:0]  lsu_rstrb;
    logic        lsu_lsign;
    logic        lsu_ready;
    logic [31:0] mem_rdata;
    logic        mem_rvld;
    logic        wb_rd_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        wb_load_pending;
    logic        wb_err;
    logic        wb_err_clr;

    // Upstream side: LSU, memory and error-clear source.
    modport master (
        output lsu_out, lsu_out_vld, lsu_rd, lsu_rd_wen, lsu_rstrb, lsu_lsign, lsu_ready,
        output mem_rdata, mem_rvld, wb_err_clr,
        input  wb_rd_wen, wb_rd, wb_wdata, wb_load_pending, wb_err
    );

    // Write-back stage side.
    modport slave (
        input  lsu_out, lsu_out_vld, lsu_rd, lsu_rd_wen, lsu_rstrb, lsu_lsign, lsu_ready,
        input  mem_rdata, mem_rvld, wb_err_clr,
        output wb_rd_wen, wb_rd, wb_wdata, wb_load_pending, wb_err
    );

endinterface

// File: rtl/mem_wb_load_align.sv
// Load data extraction: select the strobed lane and sign/zero extend to 32 bits.
module load_align
    import mem_wb_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [3:0]  i_rstrb,
    input  logic        i_lsign,
    output logic [31:0] o_data,
    output logic        o_bad_strb
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Lane select by strobe, then extend according to access width.
    always_comb begin
        w_half     = '0;
        w_byte     = '0;
        o_data     = '0;
        o_bad_strb = 1'b0;
        case (i_rstrb)
            StrbHalfLo: w_half = i_rdata[15:0];
            StrbHalfHi: w_half = i_rdata[31:16];
            StrbByte0:  w_byte = i_rdata[7:0];
            StrbByte1:  w_byte = i_rdata[15:8];
            StrbByte2:  w_byte = i_rdata[23:16];
            StrbByte3:  w_byte = i_rdata[31:24];
            default:    ;
        endcase
        case (strb_mode(i_rstrb))
            ModeWord: o_data = i_rdata;
            ModeHalf: o_data = {{16{i_lsign & w_half[15]}}, w_half};
            ModeByte: o_data = {{24{i_lsign & w_byte[7]}}, w_byte};
            default:  o_bad_strb = (i_rstrb != StrbNone);
        endcase
    end

endmodule

// File: rtl/mem_wb.sv
// Write-back stage: retires ALU results and load responses into the register file,
// waits (with a watchdog) for late load data, and flags protocol errors.
module mem_wb
    import mem_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic    CLK,
    input  logic    RSTN,
    mem_wb_if.slave bus
);

    localparam int unsigned WdogW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    wb_state_e   r_state;
    logic        r_ready;
    logic [WdogW-1:0] r_wdog;
    logic        r_wen;
    logic [4:0]  r_rd;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [4:0]  r_cap_rd;
    logic        r_cap_rd_wen;
    logic [3:0]  r_cap_rstrb;
    logic        r_cap_lsign;

    logic        w_new_entry;
    logic        w_in_wait;
    logic [3:0]  w_ld_rstrb;
    logic        w_ld_lsign;
    logic [4:0]  w_ld_rd;
    logic        w_ld_rd_wen;
    logic [31:0] w_ld_data;
    logic        w_bad_strb;
    logic        w_ld_write;

    assign w_new_entry = r_ready;
    assign w_in_wait   = (r_state == StWait);

    // A completing load uses the live LSU fields in IDLE and the captured ones in WAIT.
    assign w_ld_rstrb  = w_in_wait ? r_cap_rstrb  : bus.lsu_rstrb;
    assign w_ld_lsign  = w_in_wait ? r_cap_lsign  : bus.lsu_lsign;
    assign w_ld_rd     = w_in_wait ? r_cap_rd     : bus.lsu_rd;
    assign w_ld_rd_wen = w_in_wait ? r_cap_rd_wen : bus.lsu_rd_wen;
    assign w_ld_write  = w_ld_rd_wen && (w_ld_rd != 5'd0) && !w_bad_strb;

    load_align u_load_align (
        .i_rdata    (bus.mem_rdata),
        .i_rstrb    (w_ld_rstrb),
        .i_lsign    (w_ld_lsign),
        .o_data     (w_ld_data),
        .o_bad_strb (w_bad_strb)
    );

    // Write-back FSM with registered register-file write and sticky error.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state      <= StIdle;
            r_ready      <= 1'b0;
            r_wdog       <= '0;
            r_wen        <= 1'b0;
            r_rd         <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_cap_rd     <= '0;
            r_cap_rd_wen <= 1'b0;
            r_cap_rstrb  <= '0;
            r_cap_lsign  <= 1'b0;
        end else begin
            r_ready <= bus.lsu_ready;
            r_wen   <= 1'b0;
            // Clear first; any set below in the same cycle overrides it.
            if (bus.wb_err_clr) begin
                r_err <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_new_entry && (bus.lsu_rstrb != StrbNone)) begin
                        if (bus.mem_rvld) begin
                            if (w_bad_strb) begin
                                r_err <= 1'b1;
                            end else if (w_ld_write) begin
                                r_wen   <= 1'b1;
                                r_rd    <= w_ld_rd;
                                r_wdata <= w_ld_data;
                            end
                        end else begin
                            r_cap_rd     <= bus.lsu_rd;
                            r_cap_rd_wen <= bus.lsu_rd_wen;
                            r_cap_rstrb  <= bus.lsu_rstrb;
                            r_cap_lsign  <= bus.lsu_lsign;
                            r_wdog       <= '0;
                            r_state      <= StWait;
                        end
                    end else begin
                        if (w_new_entry && bus.lsu_out_vld && bus.lsu_rd_wen &&
                            (bus.lsu_rd != 5'd0)) begin
                            r_wen   <= 1'b1;
                            r_rd    <= bus.lsu_rd;
                            r_wdata <= bus.lsu_out;
                        end
                        // No load is outstanding, so any response is spurious.
                        if (bus.mem_rvld) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    if (bus.mem_rvld) begin
                        r_state <= StIdle;
                        if (w_bad_strb) begin
                            r_err <= 1'b1;
                        end else if (w_ld_write) begin
                            r_wen   <= 1'b1;
                            r_rd    <= w_ld_rd;
                            r_wdata <= w_ld_data;
                        end
                    end else if (r_wdog == WdogW'(TIMEOUT - 1)) begin
                        r_state <= StIdle;
                        r_err   <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.wb_rd_wen       = r_wen;
    assign bus.wb_rd           = r_rd;
    assign bus.wb_wdata        = r_wdata;
    assign bus.wb_load_pending = w_in_wait;
    assign bus.wb_err          = r_err;

endmodule

// File: tb/tb_mem_wb.sv
// Directed self-checking bench for the write-back stage.
module tb_mem_wb;

    logic clk;
    logic rstn;
    int   n_total;
    int   n_bad;

    mem_wb_if bus ();

    mem_wb #(
        .TIMEOUT (4)
    ) u_dut (
        .CLK  (clk),
        .RSTN (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.lsu_out     = '0;
        bus.lsu_out_vld = 1'b0;
        bus.lsu_rd      = '0;
        bus.lsu_rd_wen  = 1'b0;
        bus.lsu_rstrb   = '0;
        bus.lsu_lsign   = 1'b0;
        bus.lsu_ready   = 1'b0;
        bus.mem_rdata   = '0;
        bus.mem_rvld    = 1'b0;
        bus.wb_err_clr  = 1'b0;
    endtask

    // Raise lsu_ready for a cycle, then present one LSU word while new_entry is high.
    task automatic issue(input logic [31:0] out, input logic vld, input logic [4:0] rd,
                         input logic wen, input logic [3:0] strb, input logic lsign,
                         input logic rvld, input logic [31:0] rdata);
        bus.lsu_ready = 1'b1;
        step();
        bus.lsu_ready   = 1'b0;
        bus.lsu_out     = out;
        bus.lsu_out_vld = vld;
        bus.lsu_rd      = rd;
        bus.lsu_rd_wen  = wen;
        bus.lsu_rstrb   = strb;
        bus.lsu_lsign   = lsign;
        bus.mem_rvld    = rvld;
        bus.mem_rdata   = rdata;
        step();
        clear_inputs();
    endtask

    task automatic clear_err();
        bus.wb_err_clr = 1'b1;
        step();
        bus.wb_err_clr = 1'b0;
    endtask

    // Same-cycle load vectors: strobe, sign, rdata, expected wdata.
    logic [3:0]  v_strb  [6] = '{4'b0100, 4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0011};
    logic        v_sign  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] v_rdata [6] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_00F0,
                                 32'h0000_7F00, 32'h8100_0000, 32'h0000_8001};
    logic [31:0] v_exp   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FFF0,
                                 32'h0000_007F, 32'h0000_0081, 32'hFFFF_8001};

    initial begin
        n_total = 0;
        n_bad   = 0;
        clear_inputs();
        rstn = 1'b0;
        step();
        step();
        check_eq("rst_wen", {31'd0, bus.wb_rd_wen}, 32'd0);
        check_eq("rst_rd", {27'd0, bus.wb_rd}, 32'd0);
        check_eq("rst_wdata", bus.wb_wdata, 32'd0);
        check_eq("rst_err", {31'd0, bus.wb_err}, 32'd0);
        check_eq("rst_pend", {31'd0, bus.wb_load_pending}, 32'd0);
        rstn = 1'b1;
        step();

        // ALU write, then the pulse drops and the data holds.
        issue(32'h1234_5678, 1'b1, 5'd5, 1'b1, 4'b0000, 1'b0, 1'b0, 32'd0);
        check_eq("alu_wen", {31'd0, bus.wb_rd_wen}, 32'd1);
        check_eq("alu_rd", {27'd0, bus.wb_rd}, 32'd5);
        check_eq("alu_wdata", bus.wb_wdata, 32'h1234_5678);
        step();
        check_eq("alu_pulse", {31'd0, bus.wb_rd_wen}, 32'd0);
        check_eq("alu_hold", bus.wb_wdata, 32'h1234_5678);

        // ALU word without rd_wen or without vld: nothing written.
        issue(32'hAAAA_AAAA, 1'b1, 5'd6, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0);
        check_eq("alu_nowen", {31'd0, bus.wb_rd_wen}, 32'd0);
        issue(32'hBBBB_BBBB, 1'b0, 5'd6, 1'b1, 4'b0000, 1'b0, 1'b0, 32'd0);
        check_eq("alu_novld", {31'd0, bus.wb_rd_wen}, 32'd0);
        check_eq("alu_novld_hold", bus.wb_wdata, 32'h1234_5678);

        // Same-cycle loads over several lanes and widths.
        for (int i = 0; i < 6; i++) begin
            issue(32'd0, 1'b0, 5'd3, 1'b1, v_strb[i], v_sign[i], 1'b1, v_rdata[i]);
            check_eq($sformatf("ld%0d_wen", i), {31'd0, bus.wb_rd_wen}, 32'd1);
            check_eq($sformatf("ld%0d_wdata", i), bus.wb_wdata, v_exp[i]);
            check_eq($sformatf("ld%0d_pend", i), {31'd0, bus.wb_load_pending}, 32'd0);
        end
        issue(32'd0, 1'b0, 5'd3, 1'b1, 4'b1111, 1'b1, 1'b1, 32'hCAFE_F00D);
        check_eq("lw_wdata", bus.wb_wdata, 32'hCAFE_F00D);
        check_eq("ld_err", {31'd0, bus.wb_err}, 32'd0);

        // Stalled LHU: three WAIT cycles, response arrives in the third.
        issue(32'd0, 1'b0, 5'd7, 1'b1, 4'b1100, 1'b0, 1'b0, 32'd0);
        check_eq("lhu_pend1", {31'd0, bus.wb_load_pending}, 32'd1);
        step();
        check_eq("lhu_pend2", {31'd0, bus.wb_load_pending}, 32'd1);
        step();
        check_eq("lhu_pend3", {31'd0, bus.wb_load_pending}, 32'd1);
        check_eq("lhu_nowr", {31'd0, bus.wb_rd_wen}, 32'd0);
        bus.mem_rvld  = 1'b1;
        bus.mem_rdata = 32'hBEEF_0000;
        step();
        clear_inputs();
        check_eq("lhu_wen", {31'd0, bus.wb_rd_wen}, 32'd1);
        check_eq("lhu_rd", {27'd0, bus.wb_rd}, 32'd7);
        check_eq("lhu_wdata", bus.wb_wdata, 32'h0000_BEEF);
        check_eq("lhu_pend0", {31'd0, bus.wb_load_pending}, 32'd0);
        check_eq("lhu_err", {31'd0, bus.wb_err}, 32'd0);

        // Timeout after four WAIT cycles with no response.
        issue(32'd0, 1'b0, 5'd9, 1'b1, 4'b1111, 1'b0, 1'b0, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            check_eq($sformatf("to_pend%0d", c), {31'd0, bus.wb_load_pending}, 32'd1);
            check_eq($sformatf("to_err%0d", c), {31'd0, bus.wb_err}, 32'd0);
            step();
        end
        check_eq("to_idle", {31'd0, bus.wb_load_pending}, 32'd0);
        check_eq("to_err", {31'd0, bus.wb_err}, 32'd1);
        check_eq("to_nowr", {31'd0, bus.wb_rd_wen}, 32'd0);
        check_eq("to_rd_hold", {27'd0, bus.wb_rd}, 32'd7);
        clear_err();
        check_eq("to_clr", {31'd0, bus.wb_err}, 32'd0);

        // Load to x0 completes silently; spurious response sets the error.
        issue(32'd0, 1'b0, 5'd0, 1'b1, 4'b1111, 1'b0, 1'b1, 32'h1111_2222);
        check_eq("x0_nowr", {31'd0, bus.wb_rd_wen}, 32'd0);
        check_eq("x0_noerr", {31'd0, bus.wb_err}, 32'd0);
        check_eq("x0_hold", bus.wb_wdata, 32'h0000_BEEF);
        bus.mem_rvld = 1'b1;
        step();
        clear_inputs();
        check_eq("spur_nowr", {31'd0, bus.wb_rd_wen}, 32'd0);
        check_eq("spur_err", {31'd0, bus.wb_err}, 32'd1);
        clear_err();

        // Illegal strobe: no write, error set.
        issue(32'd0, 1'b0, 5'd4, 1'b1, 4'b0101, 1'b0, 1'b1, 32'h1234_5678);
        check_eq("bad_nowr", {31'd0, bus.wb_rd_wen}, 32'd0);
        check_eq("bad_err", {31'd0, bus.wb_err}, 32'd1);
        clear_err();
        check_eq("bad_clr", {31'd0, bus.wb_err}, 32'd0);

        // Set and clear in the same cycle: set wins.
        bus.wb_err_clr = 1'b1;
        bus.mem_rvld   = 1'b1;
        step();
        clear_inputs();
        check_eq("setclr_err", {31'd0, bus.wb_err}, 32'd1);
        clear_err();

        // Reset while waiting clears everything immediately; later response is spurious.
        issue(32'd0, 1'b0, 5'd10, 1'b1, 4'b1111, 1'b0, 1'b0, 32'd0);
        check_eq("rw_pend", {31'd0, bus.wb_load_pending}, 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("rw_pend0", {31'd0, bus.wb_load_pending}, 32'd0);
        check_eq("rw_rd0", {27'd0, bus.wb_rd}, 32'd0);
        check_eq("rw_wdata0", bus.wb_wdata, 32'd0);
        step();
        rstn          = 1'b1;
        bus.mem_rvld  = 1'b1;
        bus.mem_rdata = 32'h5555_AAAA;
        step();
        clear_inputs();
        check_eq("rw_nowr", {31'd0, bus.wb_rd_wen}, 32'd0);
        check_eq("rw_wdata", bus.wb_wdata, 32'd0);
        check_eq("rw_err", {31'd0, bus.wb_err}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
